// File: rtl/database_stage_reader.sv
// Consumer side of one streamed stage database: fetches classifier records and
// stage thresholds word by word and hands records to the feature evaluator.
module database_stage_reader #(
  parameter int unsigned DATA_WIDTH_16            = 16,
  parameter int unsigned DATA_WIDTH_12            = 12,
  parameter int unsigned NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int unsigned NUM_STAGE_THRESHOLD      = 3,
  parameter int unsigned NUM_CLASSIFIERS_STAGE    = 32
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              i_start,
  output logic                                              o_enable,
  input  logic [DATA_WIDTH_16-1:0]                          i_data,
  input  logic                                              i_end_database,
  output logic                                              o_classifier_valid,
  input  logic                                              i_classifier_ready,
  output logic [NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_16-1:0] o_classifier_param,
  output logic [DATA_WIDTH_12-1:0]                          o_classifier_index,
  output logic [NUM_STAGE_THRESHOLD*DATA_WIDTH_16-1:0]      o_stage_threshold,
  output logic                                              o_done,
  output logic                                              o_busy,
  output logic                                              o_error
);

  localparam int unsigned DW   = DATA_WIDTH_16;
  localparam int unsigned IW   = DATA_WIDTH_12;
  localparam int unsigned NP   = NUM_PARAM_PER_CLASSIFIER;
  localparam int unsigned NT   = NUM_STAGE_THRESHOLD;
  localparam int unsigned NC   = NUM_CLASSIFIERS_STAGE;
  localparam int unsigned PW   = NP * DW;
  localparam int unsigned TW   = NT * DW;
  localparam int unsigned MAXW = (NP > NT) ? NP : NT;
  localparam int unsigned CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_PRESENT, S_TFETCH, S_TDRAIN, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   req_cnt_q, req_cnt_d;
  logic [CW-1:0]   rcv_cnt_q, rcv_cnt_d;
  logic            in_flight_q, in_flight_d;
  logic [PW-1:0]   param_q, param_d;
  logic [TW-1:0]   thresh_q, thresh_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            enable_q, enable_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            error_q, error_d;

  logic            capture_c;
  logic            thr_mode_c;
  logic            last_word_c;
  logic            flag_bad_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      req_cnt_q   <= '0;
      rcv_cnt_q   <= '0;
      in_flight_q <= 1'b0;
      param_q     <= '0;
      thresh_q    <= '0;
      idx_q       <= '0;
      enable_q    <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_cnt_q   <= req_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      in_flight_q <= in_flight_d;
      param_q     <= param_d;
      thresh_q    <= thresh_d;
      idx_q       <= idx_d;
      enable_q    <= enable_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  // Next-state, word capture and registered output decode
  always_comb begin
    state_d     = state_q;
    req_cnt_d   = req_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    in_flight_d = enable_q;
    param_d     = param_q;
    thresh_d    = thresh_q;
    idx_d       = idx_q;
    error_d     = error_q;

    // A word is on i_data exactly one cycle after its request cycle
    capture_c   = in_flight_q && (state_q inside {S_FETCH, S_DRAIN, S_TFETCH, S_TDRAIN});
    thr_mode_c  = state_q inside {S_TFETCH, S_TDRAIN};
    last_word_c = thr_mode_c && (rcv_cnt_q == CW'(NT - 1));
    flag_bad_c  = capture_c && (i_end_database != last_word_c);

    if (capture_c) begin
      rcv_cnt_d = rcv_cnt_q + CW'(1);
      for (int unsigned k = 0; k < NP; k++) begin
        if (!thr_mode_c && (rcv_cnt_q == CW'(k))) param_d[k*DW +: DW] = i_data;
      end
      for (int unsigned k = 0; k < NT; k++) begin
        if (thr_mode_c && (rcv_cnt_q == CW'(k))) thresh_d[k*DW +: DW] = i_data;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d   = S_FETCH;
          idx_d     = '0;
          req_cnt_d = '0;
          rcv_cnt_d = '0;
          error_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (req_cnt_q == CW'(NP - 1)) begin
          req_cnt_d = '0;
          state_d   = S_DRAIN;
        end else begin
          req_cnt_d = req_cnt_q + CW'(1);
        end
      end
      S_DRAIN:   state_d = S_PRESENT;
      S_PRESENT: begin
        if (i_classifier_ready) begin
          rcv_cnt_d = '0;
          if (idx_q < IW'(NC - 1)) begin
            idx_d   = idx_q + IW'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_TFETCH;
          end
        end
      end
      S_TFETCH: begin
        if (req_cnt_q == CW'(NT - 1)) begin
          req_cnt_d = '0;
          state_d   = S_TDRAIN;
        end else begin
          req_cnt_d = req_cnt_q + CW'(1);
        end
      end
      S_TDRAIN: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase

    // End-flag violation aborts the stage, dropping any partial record
    if (flag_bad_c) begin
      state_d   = S_DONE;
      req_cnt_d = '0;
      error_d   = 1'b1;
    end

    enable_d = state_d inside {S_FETCH, S_TFETCH};
    valid_d  = (state_d == S_PRESENT);
    done_d   = (state_d == S_DONE);
    busy_d   = !(state_d inside {S_IDLE, S_DONE});
  end

  assign o_enable           = enable_q;
  assign o_classifier_valid = valid_q;
  assign o_classifier_param = param_q;
  assign o_classifier_index = idx_q;
  assign o_stage_threshold  = thresh_q;
  assign o_done             = done_q;
  assign o_busy             = busy_q;
  assign o_error            = error_q;

endmodule

// File: tb/tb_database_stage_reader.sv
// Bench for database_stage_reader: 2-classifier stage fed by an address-valued ROM,
// records and completions checked by a queue-based monitor.
module tb_database_stage_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned NP = 18;
  localparam int unsigned NT = 3;
  localparam int unsigned NC = 2;
  localparam int unsigned PW = NP * DW;
  localparam int unsigned TW = NT * DW;
  localparam logic [TW-1:0] THR_EXP = {16'd38, 16'd37, 16'd36};

  typedef struct packed {
    logic [PW-1:0] param;
    logic [11:0]   idx;
  } rec_t;

  typedef struct packed {
    logic          chk_thr;
    logic [TW-1:0] thr;
    logic          err;
  } fin_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_start = 1'b0;
  logic          o_enable;
  logic [DW-1:0] i_data;
  logic          i_end_database = 1'b0;
  logic          o_classifier_valid;
  logic          i_classifier_ready = 1'b0;
  logic [PW-1:0] o_classifier_param;
  logic [11:0]   o_classifier_index;
  logic [TW-1:0] o_stage_threshold;
  logic          o_done;
  logic          o_busy;
  logic          o_error;

  logic          rom_clr = 1'b0;
  int            rom_addr = 0;
  int            end_at = 38;

  int            checks = 0;
  int            errors = 0;
  rec_t          rec_q[$];
  fin_t          fin_q[$];

  database_stage_reader #(
    .DATA_WIDTH_16(16),
    .DATA_WIDTH_12(12),
    .NUM_PARAM_PER_CLASSIFIER(NP),
    .NUM_STAGE_THRESHOLD(NT),
    .NUM_CLASSIFIERS_STAGE(NC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_start(i_start),
    .o_enable(o_enable),
    .i_data(i_data),
    .i_end_database(i_end_database),
    .o_classifier_valid(o_classifier_valid),
    .i_classifier_ready(i_classifier_ready),
    .o_classifier_param(o_classifier_param),
    .o_classifier_index(o_classifier_index),
    .o_stage_threshold(o_stage_threshold),
    .o_done(o_done),
    .o_busy(o_busy),
    .o_error(o_error)
  );

  always #5 clk = ~clk;

  // One-cycle-latency ROM whose word equals its address
  always @(posedge clk) begin
    if (rom_clr) rom_addr <= 0;
    else if (o_enable) rom_addr <= rom_addr + 1;
    if (o_enable) begin
      i_data         <= DW'(rom_addr);
      i_end_database <= (rom_addr == end_at);
    end else begin
      i_data         <= 16'hdead;
      i_end_database <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [PW-1:0] exp_rec(input int r);
    logic [PW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(NP); k++) v[k*DW +: DW] = DW'(18 * r + k);
    return v;
  endfunction

  function automatic rec_t mk_rec(input int r);
    rec_t x;
    x.param = exp_rec(r);
    x.idx   = 12'(r);
    return x;
  endfunction

  function automatic fin_t mk_fin(input logic c, input logic [TW-1:0] t, input logic e);
    fin_t f;
    f.chk_thr = c;
    f.thr     = t;
    f.err     = e;
    return f;
  endfunction

  // Monitor: consumes expected records on handshakes and completions on done rising
  initial begin
    logic done_prev;
    rec_t r;
    fin_t f;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && o_classifier_valid && i_classifier_ready) begin
        if (rec_q.size() == 0) begin
          timeout("unexpected_record");
        end else begin
          r = rec_q.pop_front();
          chk("rec_param", o_classifier_param, r.param);
          chk("rec_index", PW'(o_classifier_index), PW'(r.idx));
        end
      end
      if (reset && o_done && !done_prev) begin
        if (fin_q.size() == 0) begin
          timeout("unexpected_done");
        end else begin
          f = fin_q.pop_front();
          chk("fin_error", PW'(o_error), PW'(f.err));
          chk("fin_busy", PW'(o_busy), PW'(0));
          if (f.chk_thr) chk("fin_threshold", PW'(o_stage_threshold), PW'(f.thr));
        end
      end
      done_prev = o_done;
    end
  end

  task automatic start_stream();
    @(posedge clk);
    #1 i_start = 1'b1;
    rom_clr = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    rom_clr = 1'b0;
  endtask

  task automatic push_basic();
    rec_q.push_back(mk_rec(0));
    rec_q.push_back(mk_rec(1));
    fin_q.push_back(mk_fin(1'b1, THR_EXP, 1'b0));
  endtask

  // Counts negedges from cycle S+1 until o_done; optionally pulses i_start at cycle poke_at
  task automatic run_until_done(input int poke_at, output int t_valid, output int t_done,
                                output int en_cnt);
    int n;
    n = 0;
    t_valid = 0;
    t_done = 0;
    en_cnt = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (o_enable) en_cnt++;
      if (o_classifier_valid && t_valid == 0) t_valid = n;
      if (n == poke_at) begin
        chk("busy_at_poke", PW'(o_busy), PW'(1));
        i_start = 1'b1;
      end
      if (n == poke_at + 1) i_start = 1'b0;
      if (o_done) begin
        t_done = n;
        break;
      end
    end
    if (t_done == 0) timeout("wait_done");
  endtask

  task automatic check_timing(input string tag, input int tv, input int td, input int en,
                              input int ev, input int ed, input int ee);
    chk({tag, "_valid_cycle"}, PW'(tv), PW'(ev));
    chk({tag, "_done_cycle"}, PW'(td), PW'(ed));
    chk({tag, "_enable_cycles"}, PW'(en), PW'(ee));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_enable"}, PW'(o_enable), PW'(0));
    chk({tag, "_valid"}, PW'(o_classifier_valid), PW'(0));
    chk({tag, "_done"}, PW'(o_done), PW'(0));
    chk({tag, "_busy"}, PW'(o_busy), PW'(0));
    chk({tag, "_error"}, PW'(o_error), PW'(0));
    chk({tag, "_index"}, PW'(o_classifier_index), PW'(0));
    chk({tag, "_param"}, o_classifier_param, PW'(0));
    chk({tag, "_threshold"}, PW'(o_stage_threshold), PW'(0));
  endtask

  initial begin
    int tv, td, en, n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Basic stream with ready tied high
    i_classifier_ready = 1'b1;
    end_at = 38;
    push_basic();
    start_stream();
    run_until_done(-1, tv, td, en);
    check_timing("basic", tv, td, en, 20, 45, 39);

    // Backpressure on record 0
    i_classifier_ready = 1'b0;
    push_basic();
    start_stream();
    n = 0;
    while (!o_classifier_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_classifier_valid) timeout("bp_wait_valid");
    chk("bp_valid_cycle", PW'(n), PW'(20));
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid_held", PW'(o_classifier_valid), PW'(1));
      chk("bp_enable_low", PW'(o_enable), PW'(0));
      chk("bp_param_stable", o_classifier_param, exp_rec(0));
    end
    @(posedge clk);
    #1 i_classifier_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_valid_dropped", PW'(o_classifier_valid), PW'(0));
    chk("bp_refetch_enable", PW'(o_enable), PW'(1));
    run_until_done(-1, tv, td, en);
    chk("bp_done_seen", PW'(o_done), PW'(1));

    // End flag arrives early with word 20
    end_at = 20;
    rec_q.push_back(mk_rec(0));
    fin_q.push_back(mk_fin(1'b0, '0, 1'b1));
    start_stream();
    run_until_done(-1, tv, td, en);
    check_timing("early", tv, td, en, 20, 25, 22);
    chk("early_error", PW'(o_error), PW'(1));

    // End flag never asserted
    end_at = 999;
    rec_q.push_back(mk_rec(0));
    rec_q.push_back(mk_rec(1));
    fin_q.push_back(mk_fin(1'b1, THR_EXP, 1'b1));
    start_stream();
    run_until_done(-1, tv, td, en);
    check_timing("missing", tv, td, en, 20, 45, 39);

    // Reset asserted during record 0 fetch, then a clean restart
    end_at = 38;
    start_stream();
    repeat (7) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (3) @(negedge clk);
    chk("midreset_stray_ignored", o_classifier_param, PW'(0));
    push_basic();
    start_stream();
    run_until_done(-1, tv, td, en);
    check_timing("restart", tv, td, en, 20, 45, 39);

    // i_start while busy is ignored
    push_basic();
    start_stream();
    run_until_done(5, tv, td, en);
    check_timing("ignored", tv, td, en, 20, 45, 39);

    repeat (5) @(negedge clk);
    chk("rec_queue_empty", PW'(rec_q.size()), PW'(0));
    chk("fin_queue_empty", PW'(fin_q.size()), PW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
